game_step_sequencer: RTL and testbench
======================================

GAME_STEP_SEQUENCER -- requirements
Module: game_step_sequencer

Interface
REQ-001 Parameter DONE_TIMEOUT, default 1024: max MasterClock cycles a phase waits for its done before faulting.
REQ-002 MasterClock  in  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 tick  in  1  single-cycle base-rate strobe (2 Hz), synchronous to MasterClock.
REQ-005 run  in  1  level; 1 = game running, 0 = paused.
REQ-006 speed  in  2  step rate; a step launches every (4 - speed) accepted ticks (0 -> 4 ticks, 3 -> 1 tick).
REQ-007 moveReq / checkReq / drawReq  out  1 each  level requests to the move, collision-check and render units.
REQ-008 moveDone / checkDone / drawDone  in  1 each  single-cycle completion strobes from those units.
REQ-009 gameOver  in  1  collision result; valid only in the cycle checkDone is high.
REQ-010 busy  out  1  high in MOVE, CHECK, DRAW.
REQ-011 halted  out  1  high in HALT.  fault  out  1  high in FAULT.
REQ-012 overrun  out  1  sticky; set when a tick arrives while busy.
REQ-013 stepCount  out  16  completed steps.

Function
REQ-014 FSM states IDLE, MOVE, CHECK, DRAW, HALT, FAULT; exactly one request high in MOVE/CHECK/DRAW, none elsewhere.
REQ-015 IDLE: tick with run=1 is accepted; a 2-bit tickCnt increments; if tickCnt+1 >= 4-speed, tickCnt clears and the FSM enters MOVE next cycle (moveReq high one cycle after the tick).
REQ-016 run=0: ticks ignored, tickCnt holds; a step in progress completes normally.
REQ-017 speed is sampled only at an accepted tick; if tickCnt already >= the new threshold, that tick launches.
REQ-018 MOVE -> CHECK on moveDone; CHECK -> DRAW on checkDone with gameOver=0, CHECK -> HALT on checkDone with gameOver=1; DRAW -> IDLE on drawDone; the request drops the cycle after its done.
REQ-019 A done strobe for a phase other than the current one is ignored.
REQ-020 stepCount increments on drawDone in DRAW; wraps 0xFFFF -> 0x0000.
REQ-021 Tick while busy: dropped (tickCnt unchanged), overrun set; a tick in HALT or FAULT is ignored, overrun unchanged.
REQ-022 Per-phase timeout counter clears on each phase entry; reaching DONE_TIMEOUT cycles without done -> FAULT; a done arriving in the timeout cycle wins.
REQ-023 HALT and FAULT are exited only by Reset.

Reset
REQ-024 Reset asserted: FSM = IDLE, tickCnt = 0, timeout counter = 0, stepCount = 0, all requests, busy, halted, fault, overrun = 0, asynchronously and regardless of clock.
REQ-025 Reset mid-phase drops the active request immediately; a done arriving in the first cycle after deassertion is ignored.

Configuration
REQ-026 Macro SEQ_SINGLE_STEP_EN defined: adds input stepBtn (1, single-cycle strobe); in IDLE with run=0, stepBtn launches one step (MOVE next cycle) without touching tickCnt; stepBtn with run=1 or while not IDLE is ignored.
REQ-027 Macro undefined: stepBtn port absent; steps launch only via REQ-015.

Verification
REQ-028 speed=3, run=1, tick once, each done returned 2 cycles after its req -> moveReq, checkReq, drawReq in order, stepCount=1, back in IDLE.
REQ-029 speed=0, 3 ticks -> no moveReq; 4th tick -> moveReq next cycle; run=0 then 10 ticks -> no request.
REQ-030 Tick during CHECK -> overrun=1, tickCnt unchanged, step completes; overrun stays 1 until Reset.
REQ-031 checkDone with gameOver=1 -> HALT, halted=1, drawReq never asserted, later ticks ignored.
REQ-032 DONE_TIMEOUT=8, moveDone withheld -> fault=1 exactly 8 cycles after MOVE entry, moveReq low; Reset -> all outputs 0.
REQ-033 SEQ_SINGLE_STEP_EN defined, run=0, stepBtn pulse -> one full step, stepCount +1; stepBtn with run=1 -> no effect.

Source files
------------

// File: rtl/game_step_sequencer_if.sv
// Handshake bundle between the step sequencer and its move/check/render units.
// The stepBtn signal only exists when SEQ_SINGLE_STEP_EN is defined.
interface game_step_sequencer_if;
   logic        tick;
   logic        run;
   logic [1:0]  speed;
   logic        moveReq;
   logic        checkReq;
   logic        drawReq;
   logic        moveDone;
   logic        checkDone;
   logic        drawDone;
   logic        gameOver;
   logic        busy;
   logic        halted;
   logic        fault;
   logic        overrun;
   logic [15:0] stepCount;
`ifdef SEQ_SINGLE_STEP_EN
   logic        stepBtn;
`endif

   // master: the sequencer itself
   modport master (
`ifdef SEQ_SINGLE_STEP_EN
      input  stepBtn,
`endif
      input  tick, run, speed, moveDone, checkDone, drawDone, gameOver,
      output moveReq, checkReq, drawReq, busy, halted, fault, overrun, stepCount
   );

   // slave: the game environment and the three worker units
   modport slave (
`ifdef SEQ_SINGLE_STEP_EN
      output stepBtn,
`endif
      output tick, run, speed, moveDone, checkDone, drawDone, gameOver,
      input  moveReq, checkReq, drawReq, busy, halted, fault, overrun, stepCount
   );
endinterface

// File: rtl/game_step_sequencer.sv
// Game step sequencer: paces MOVE -> CHECK -> DRAW steps off a tick strobe, with per-phase timeout.
// Optional SEQ_SINGLE_STEP_EN adds a stepBtn that launches one step while paused.
module game_step_sequencer #(
   parameter int DONE_TIMEOUT = 1024
) (
   input  logic                   i_MasterClock,
   input  logic                   i_Reset,
   game_step_sequencer_if.master  io_bus
);
   localparam int TW = (DONE_TIMEOUT < 2) ? 1 : $clog2(DONE_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_MOVE, S_CHECK, S_DRAW, S_HALT, S_FAULT
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [1:0]    r_tick_cnt, w_tick_cnt_nxt;
   logic [TW-1:0] r_tmo;
   logic [15:0]   r_step_cnt;
   logic          r_overrun;
   logic          w_busy, w_accept, w_step, w_tmo_hit;
   logic [2:0]    w_tick_sum, w_thresh;

`ifdef SEQ_SINGLE_STEP_EN
   assign w_step = io_bus.stepBtn && !io_bus.run;
`else
   assign w_step = 1'b0;
`endif

   assign w_busy     = (r_state == S_MOVE) || (r_state == S_CHECK) || (r_state == S_DRAW);
   assign w_accept   = (r_state == S_IDLE) && io_bus.tick && io_bus.run;
   assign w_tick_sum = {1'b0, r_tick_cnt} + 3'd1;
   assign w_thresh   = 3'd4 - {1'b0, io_bus.speed};
   assign w_tmo_hit  = (r_tmo == TMO_LAST);

   always_comb begin
      w_state_nxt    = r_state;
      w_tick_cnt_nxt = r_tick_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_tick_sum >= w_thresh) begin
                  w_tick_cnt_nxt = 2'd0;
                  w_state_nxt    = S_MOVE;
               end else begin
                  w_tick_cnt_nxt = w_tick_sum[1:0];
               end
            end else if (w_step) begin
               w_state_nxt = S_MOVE;
            end
         end
         // a done landing in the timeout cycle takes priority over the fault
         S_MOVE: begin
            if (io_bus.moveDone)  w_state_nxt = S_CHECK;
            else if (w_tmo_hit)   w_state_nxt = S_FAULT;
         end
         S_CHECK: begin
            if (io_bus.checkDone) w_state_nxt = io_bus.gameOver ? S_HALT : S_DRAW;
            else if (w_tmo_hit)   w_state_nxt = S_FAULT;
         end
         S_DRAW: begin
            if (io_bus.drawDone)  w_state_nxt = S_IDLE;
            else if (w_tmo_hit)   w_state_nxt = S_FAULT;
         end
         default: w_state_nxt = r_state;
      endcase
   end

   always_ff @(posedge i_MasterClock or posedge i_Reset) begin
      if (i_Reset) begin
         r_state    <= S_IDLE;
         r_tick_cnt <= 2'd0;
         r_tmo      <= '0;
         r_step_cnt <= 16'd0;
         r_overrun  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_cnt_nxt;
         if ((w_state_nxt != r_state) || !w_busy) r_tmo <= '0;
         else                                     r_tmo <= r_tmo + 1'b1;
         if ((r_state == S_DRAW) && io_bus.drawDone) r_step_cnt <= r_step_cnt + 16'd1;
         if (w_busy && io_bus.tick)                  r_overrun  <= 1'b1;
      end
   end

   assign io_bus.moveReq   = (r_state == S_MOVE);
   assign io_bus.checkReq  = (r_state == S_CHECK);
   assign io_bus.drawReq   = (r_state == S_DRAW);
   assign io_bus.busy      = w_busy;
   assign io_bus.halted    = (r_state == S_HALT);
   assign io_bus.fault     = (r_state == S_FAULT);
   assign io_bus.overrun   = r_overrun;
   assign io_bus.stepCount = r_step_cnt;
endmodule

// File: tb/tb_game_step_sequencer.sv
// Directed plus randomized bench for game_step_sequencer; reference model tracks
// accepted-tick accumulation, step count and overrun with plain integers.
module tb_game_step_sequencer;
   logic clk, rst;
   int   total = 0;
   int   bad   = 0;

   game_step_sequencer_if bus();

   game_step_sequencer #(.DONE_TIMEOUT(8)) dut (
      .i_MasterClock (clk),
      .i_Reset       (rst),
      .io_bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
   endtask

   function automatic logic get_req(input int ph);
      case (ph)
         0:       return bus.moveReq;
         1:       return bus.checkReq;
         default: return bus.drawReq;
      endcase
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"}, {29'd0, bus.moveReq, bus.checkReq, bus.drawReq}, 32'd0);
      chk({tag, "_flags"}, {28'd0, bus.busy, bus.halted, bus.fault, bus.overrun}, 32'd0);
      chk({tag, "_steps"}, {16'd0, bus.stepCount}, 32'd0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      chk_all_zero(tag);
      step();
      rst = 1'b0;
   endtask

   // Act as the worker unit for one phase: wait for its request, return done after dly cycles.
   task automatic serve(input int ph, input int dly, input bit go, input bit tk);
      for (int i = 0; i < 20 && !get_req(ph); i++) step();
      chk($sformatf("req_seen_ph%0d", ph), {31'd0, get_req(ph)}, 32'd1);
      for (int i = 0; i < dly; i++) begin
         if (tk && i == 0) bus.tick = 1'b1;
         step();
         bus.tick = 1'b0;
      end
      case (ph)
         0:       bus.moveDone  = 1'b1;
         1:       begin bus.checkDone = 1'b1; bus.gameOver = go; end
         default: bus.drawDone  = 1'b1;
      endcase
      step();
      bus.moveDone = 1'b0; bus.checkDone = 1'b0; bus.drawDone = 1'b0; bus.gameOver = 1'b0;
      chk($sformatf("req_drop_ph%0d", ph), {31'd0, get_req(ph)}, 32'd0);
   endtask

   task automatic full_step(input int dly);
      serve(0, dly, 1'b0, 1'b0);
      serve(1, dly, 1'b0, 1'b0);
      serve(2, dly, 1'b0, 1'b0);
   endtask

   int  m_acc, m_steps, sp, dly;
   bit  m_ovr, rn, launch, tk;

   initial begin
      rst = 1'b1;
      bus.tick = 1'b0; bus.run = 1'b0; bus.speed = 2'd0;
      bus.moveDone = 1'b0; bus.checkDone = 1'b0; bus.drawDone = 1'b0; bus.gameOver = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      bus.stepBtn = 1'b0;
`endif
      do_reset("reset0");
      step();

      // one step at speed 3
      bus.run = 1'b1; bus.speed = 2'd3;
      pulse_tick();
      chk("s3_moveReq", {31'd0, bus.moveReq}, 32'd1);
      chk("s3_busy", {31'd0, bus.busy}, 32'd1);
      serve(0, 2, 1'b0, 1'b0);
      chk("s3_checkReq", {31'd0, bus.checkReq}, 32'd1);
      serve(1, 2, 1'b0, 1'b0);
      chk("s3_drawReq", {31'd0, bus.drawReq}, 32'd1);
      serve(2, 2, 1'b0, 1'b0);
      chk("s3_steps", {16'd0, bus.stepCount}, 32'd1);
      chk("s3_idle", {31'd0, bus.busy}, 32'd0);

      // speed 0 needs four accepted ticks
      bus.speed = 2'd0;
      for (int i = 0; i < 3; i++) begin
         pulse_tick();
         chk($sformatf("s0_tick%0d", i), {31'd0, bus.moveReq}, 32'd0);
         step();
      end
      pulse_tick();
      chk("s0_tick3", {31'd0, bus.moveReq}, 32'd1);
      full_step(1);
      bus.run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         pulse_tick();
         chk($sformatf("paused_tick%0d", i), {31'd0, bus.busy}, 32'd0);
      end

      // speed re-sampled at tick: count 2, then speed 3 launches immediately
      bus.run = 1'b1;
      pulse_tick(); pulse_tick();
      chk("resample_pre", {31'd0, bus.moveReq}, 32'd0);
      bus.speed = 2'd3;
      pulse_tick();
      chk("resample_launch", {31'd0, bus.moveReq}, 32'd1);
      full_step(0);
      chk("resample_steps", {16'd0, bus.stepCount}, 32'd3);

      // overrun: tick during CHECK is dropped and does not advance the count
      bus.speed = 2'd1;
      pulse_tick(); pulse_tick();
      pulse_tick();
      chk("ovr_launch", {31'd0, bus.moveReq}, 32'd1);
      serve(0, 1, 1'b0, 1'b0);
      serve(1, 2, 1'b0, 1'b1);
      chk("ovr_set", {31'd0, bus.overrun}, 32'd1);
      serve(2, 1, 1'b0, 1'b0);
      step();
      chk("ovr_no_launch", {31'd0, bus.busy}, 32'd0);
      pulse_tick(); pulse_tick();
      chk("ovr_cnt_kept", {31'd0, bus.moveReq}, 32'd0);
      pulse_tick();
      chk("ovr_cnt_launch", {31'd0, bus.moveReq}, 32'd1);

      // wrong-phase dones ignored in MOVE
      bus.checkDone = 1'b1; bus.drawDone = 1'b1;
      step();
      bus.checkDone = 1'b0; bus.drawDone = 1'b0;
      chk("wrong_done_move", {30'd0, bus.moveReq, bus.checkReq}, 32'd2);
      full_step(1);
      chk("ovr_sticky", {31'd0, bus.overrun}, 32'd1);
      chk("ovr_steps", {16'd0, bus.stepCount}, 32'd5);

      // game over -> HALT
      bus.speed = 2'd3;
      pulse_tick();
      serve(0, 1, 1'b0, 1'b0);
      serve(1, 1, 1'b1, 1'b0);
      chk("halt_flag", {31'd0, bus.halted}, 32'd1);
      chk("halt_nodraw", {30'd0, bus.drawReq, bus.busy}, 32'd0);
      pulse_tick(); step(); step();
      chk("halt_tick_ignored", {29'd0, bus.moveReq, bus.drawReq, bus.busy}, 32'd0);
      chk("halt_stays", {31'd0, bus.halted}, 32'd1);
      chk("halt_ovr_kept", {31'd0, bus.overrun}, 32'd1);
      chk("halt_steps", {16'd0, bus.stepCount}, 32'd5);
      do_reset("reset_halt");

      // MOVE timeout after 8 cycles
      bus.speed = 2'd3;
      pulse_tick();
      chk("tmo_move", {31'd0, bus.moveReq}, 32'd1);
      repeat (7) step();
      chk("tmo_not_yet", {31'd0, bus.fault}, 32'd0);
      step();
      chk("tmo_fault", {31'd0, bus.fault}, 32'd1);
      chk("tmo_req_low", {31'd0, bus.moveReq}, 32'd0);
      pulse_tick(); step();
      chk("tmo_fault_stays", {30'd0, bus.fault, bus.busy}, 32'd2);
      do_reset("reset_fault");

      // done in the last allowed cycle beats the timeout
      pulse_tick();
      repeat (7) step();
      bus.moveDone = 1'b1;
      step();
      bus.moveDone = 1'b0;
      chk("tmo_done_wins", {30'd0, bus.checkReq, bus.fault}, 32'd2);
      serve(1, 0, 1'b0, 1'b0);
      serve(2, 0, 1'b0, 1'b0);
      chk("tmo_done_steps", {16'd0, bus.stepCount}, 32'd1);

      // async reset mid-phase; done right after release ignored
      pulse_tick();
      chk("arst_move", {31'd0, bus.moveReq}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_immediate", {31'd0, bus.moveReq}, 32'd0);
      step();
      rst = 1'b0;
      bus.moveDone = 1'b1;
      step();
      bus.moveDone = 1'b0;
      chk("arst_done_ignored", {29'd0, bus.moveReq, bus.checkReq, bus.busy}, 32'd0);
      chk("arst_steps", {16'd0, bus.stepCount}, 32'd0);

      // randomized ticks against the accumulation model
      do_reset("reset_rand");
      m_acc = 0; m_steps = 0; m_ovr = 1'b0;
      for (int it = 0; it < 40; it++) begin
         sp = $urandom_range(0, 3);
         rn = ($urandom_range(0, 3) != 0);
         bus.speed = sp[1:0]; bus.run = rn;
         pulse_tick();
         launch = 1'b0;
         if (rn) begin
            m_acc++;
            if (m_acc >= 4 - sp) begin m_acc = 0; launch = 1'b1; end
         end
         chk($sformatf("rnd%0d_launch", it), {31'd0, bus.moveReq}, {31'd0, launch});
         if (launch) begin
            tk  = ($urandom_range(0, 3) == 0);
            dly = $urandom_range(1, 3);
            serve(0, dly, 1'b0, 1'b0);
            serve(1, $urandom_range(0, 3), 1'b0, 1'b0);
            serve(2, dly, 1'b0, tk);
            if (tk) m_ovr = 1'b1;
            m_steps++;
         end
         chk($sformatf("rnd%0d_steps", it), {16'd0, bus.stepCount}, m_steps);
         chk($sformatf("rnd%0d_ovr", it), {31'd0, bus.overrun}, {31'd0, m_ovr});
      end

`ifdef SEQ_SINGLE_STEP_EN
      do_reset("reset_sstep");
      bus.run = 1'b0;
      bus.stepBtn = 1'b1;
      step();
      bus.stepBtn = 1'b0;
      chk("sstep_launch", {31'd0, bus.moveReq}, 32'd1);
      full_step(1);
      chk("sstep_steps", {16'd0, bus.stepCount}, 32'd1);
      bus.run = 1'b1; bus.speed = 2'd0;
      bus.stepBtn = 1'b1;
      step();
      bus.stepBtn = 1'b0;
      chk("sstep_run_ignored", {31'd0, bus.busy}, 32'd0);
      pulse_tick(); pulse_tick(); pulse_tick();
      chk("sstep_cnt_untouched", {31'd0, bus.moveReq}, 32'd0);
      pulse_tick();
      chk("sstep_cnt_launch", {31'd0, bus.moveReq}, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
